// File: rtl/wb_prog_loader_pkg.sv
// wb_prog_loader shared definitions.
// Register offsets, bit positions and the write-buffer entry layout.
package wb_prog_loader_pkg;

    localparam logic [15:0] OFF_CTRL    = 16'h0000;
    localparam logic [15:0] OFF_STATUS  = 16'h0004;
    localparam logic [15:0] OFF_WCOUNT  = 16'h0008;
    localparam logic [15:0] MEMWIN_BASE = 16'h8000;
    localparam logic [15:0] MEMWIN_MASK = 16'h8000;

    localparam int CTRL_HOLD   = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int ST_BUSY     = 4;
    localparam int ST_ERR      = 8;
    localparam int ST_DONE     = 9;

    // Wide enough for any word address the 64 KiB window can carry.
    localparam int ENT_AW = 30;

    typedef struct packed {
        logic [ENT_AW-1:0] addr;
        logic [31:0]       data;
        logic [3:0]        mask;
    } fifo_entry_t;

    function automatic logic is_memwin(input logic [15:0] off);
        return (off & MEMWIN_MASK) == MEMWIN_BASE;
    endfunction

endpackage

// File: rtl/wb_prog_loader_sync_fifo.sv
// Single-clock FIFO with occupancy count.
// Asynchronous reset flushes pointers and clears storage.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    // Storage, pointers and occupancy; pointers wrap since DEPTH is 2^n.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/wb_prog_loader.sv
// Wishbone program loader: holds the core in reset and streams
// a program image into instruction memory through a write buffer.
module wb_prog_loader
    import wb_prog_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          FIFO_DEPTH = 4,
    parameter int          MEM_AW     = 13
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic              mem_req_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic [3:0]        mem_wmask_o,
    input  logic              mem_gnt_i,
    output logic              core_rst_o,
    output logic              irq_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          r_ack;
    logic [31:0]   r_dat;
    logic [1:0]    r_ctrl;
    logic          r_err;
    logic          r_done;
    logic [31:0]   r_wcount;

    logic [15:0]   w_off;
    logic          w_hit;
    logic          w_memwin;
    logic          w_hold;
    logic          w_stall;
    logic          w_acc;
    logic          w_wr;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic          w_busy;
    logic [CW-1:0] w_count;
    logic [31:0]   w_status;
    logic [31:0]   w_rdata;
    logic          w_err_set;
    logic          w_err_clr;
    logic          w_done_set;
    logic          w_done_clr;
    logic          w_wc_clr;
    fifo_entry_t   w_wentry;
    fifo_entry_t   w_head;
    logic          w_unused;

    assign w_off    = wbs_adr_i[15:0];
    assign w_hold   = r_ctrl[CTRL_HOLD];
    assign w_memwin = is_memwin(w_off);
    assign w_hit    = wbs_cyc_i & wbs_stb_i & ~r_ack
                    & (wbs_adr_i[31:16] == BASE_ADDR[31:16]);
    // Only a buffered write into a full FIFO has to wait.
    assign w_stall  = w_memwin & wbs_we_i & w_hold & w_full;
    assign w_acc    = w_hit & ~w_stall;
    assign w_wr     = w_acc & wbs_we_i;
    assign w_push   = w_wr & w_memwin & w_hold;
    assign w_pop    = ~w_empty & mem_gnt_i;
    assign w_busy   = ~w_empty;

    assign w_err_set  = w_acc & w_memwin & (~wbs_we_i | ~w_hold);
    assign w_err_clr  = w_wr & (w_off == OFF_STATUS)
                      & wbs_sel_i[1] & wbs_dat_i[ST_ERR];
    assign w_done_clr = w_wr & (w_off == OFF_STATUS)
                      & wbs_sel_i[1] & wbs_dat_i[ST_DONE];
    // Busy falls exactly when the last entry leaves with no refill.
    assign w_done_set = w_pop & ~w_push & (w_count == CW'(1));
    assign w_wc_clr   = w_wr & (w_off == OFF_WCOUNT);

    assign w_wentry.addr = ENT_AW'(wbs_adr_i[MEM_AW+1:2]);
    assign w_wentry.data = wbs_dat_i;
    assign w_wentry.mask = wbs_sel_i;

    sync_fifo #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (wb_clk_i),
        .i_rst   (wb_rst_i),
        .i_push  (w_push),
        .i_wdata (w_wentry),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_status = {22'b0, r_done, r_err, 3'b0, w_busy, 4'(w_count)};
    assign w_unused = ^w_head.addr;

    // Register read mux; the memory window reads as zero.
    always_comb begin
        w_rdata = '0;
        if (!w_memwin) begin
            case (w_off)
                OFF_CTRL:   w_rdata = {30'b0, r_ctrl};
                OFF_STATUS: w_rdata = w_status;
                OFF_WCOUNT: w_rdata = r_wcount;
                default:    w_rdata = '0;
            endcase
        end
    end

    // One-cycle ack with read data captured on the same edge.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_ack <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_acc;
            r_dat <= (w_acc & ~wbs_we_i) ? w_rdata : '0;
        end
    end

    // Control, sticky status and granted-word counter.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_ctrl   <= 2'b01;
            r_err    <= 1'b0;
            r_done   <= 1'b0;
            r_wcount <= '0;
        end else begin
            if (w_wr && w_off == OFF_CTRL && wbs_sel_i[0])
                r_ctrl <= wbs_dat_i[1:0];
            r_err    <= w_err_set | (r_err & ~w_err_clr);
            r_done   <= w_done_set | (r_done & ~w_done_clr);
            r_wcount <= (w_wc_clr ? 32'd0 : r_wcount) + {31'b0, w_pop};
        end
    end

    assign wbs_ack_o   = r_ack;
    assign wbs_dat_o   = r_dat;
    assign mem_req_o   = ~w_empty;
    assign mem_addr_o  = w_head.addr[MEM_AW-1:0];
    assign mem_wdata_o = w_head.data;
    assign mem_wmask_o = w_head.mask;
    assign core_rst_o  = w_hold | w_busy;
    assign irq_o       = r_ctrl[CTRL_IRQ_EN] & r_done;

endmodule

// File: tb/tb_wb_prog_loader.sv
// Directed bench for wb_prog_loader.
// Hand-computed vectors; all checks go through one task.
module tb_wb_prog_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat;
    logic        ack;
    logic [31:0] dat_o;
    logic        req;
    logic [12:0] maddr;
    logic [31:0] mdata;
    logic [3:0]  mmask;
    logic        gnt;
    logic        crst;
    logic        irq;

    int total = 0;
    int bad   = 0;

    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];

    logic        g_req;
    logic [31:0] g_addr, g_data;
    logic [3:0]  g_mask;

    wb_prog_loader dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wbs_cyc_i   (cyc),
        .wbs_stb_i   (stb),
        .wbs_we_i    (we),
        .wbs_sel_i   (sel),
        .wbs_adr_i   (adr),
        .wbs_dat_i   (dat),
        .wbs_ack_o   (ack),
        .wbs_dat_o   (dat_o),
        .mem_req_o   (req),
        .mem_addr_o  (maddr),
        .mem_wdata_o (mdata),
        .mem_wmask_o (mmask),
        .mem_gnt_i   (gnt),
        .core_rst_o  (crst),
        .irq_o       (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && req && gnt) begin
            q_addr.push_back(32'(maddr));
            q_data.push_back(mdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic xfer(input logic w, input logic [31:0] a,
                        input logic [31:0] d, input int budget,
                        output logic [31:0] rd, output logic acked,
                        output logic ack_after);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = 4'hF;
        acked = 1'b0; rd = '0; ack_after = 1'b0;
        for (int i = 0; i < budget && !acked; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                acked  = 1'b1;
                rd     = dat_o;
                g_req  = req;
                g_addr = 32'(maddr);
                g_data = mdata;
                g_mask = mmask;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        if (acked) begin
            @(posedge clk); #1;
            ack_after = ack;
        end
    endtask

    task automatic wr(input string tag, input logic [31:0] a,
                      input logic [31:0] d);
        logic [31:0] rd;
        logic        ak, aa;
        xfer(1'b1, a, d, 8, rd, ak, aa);
        check({tag, "_ack"}, 32'(ak), 32'd1);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a,
                          input logic [31:0] exp);
        logic [31:0] rd;
        logic        ak, aa;
        xfer(1'b0, a, 32'd0, 8, rd, ak, aa);
        check({tag, "_ack"}, 32'(ak), 32'd1);
        check(tag, rd, exp);
    endtask

    localparam logic [31:0] A_CTRL = 32'h3000_0000;
    localparam logic [31:0] A_STAT = 32'h3000_0004;
    localparam logic [31:0] A_WCNT = 32'h3000_0008;

    initial begin
        logic [31:0] rd;
        logic        ak, aa;

        rst = 1'b1; cyc = 0; stb = 0; we = 0; sel = 0;
        adr = 0; dat = 0; gnt = 0;
        #1;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_dat", dat_o, 32'd0);
        check("rst_req", 32'(req), 32'd0);
        check("rst_maddr", 32'(maddr), 32'd0);
        check("rst_mdata", mdata, 32'd0);
        check("rst_mmask", 32'(mmask), 32'd0);
        check("rst_crst", 32'(crst), 32'd1);
        check("rst_irq", 32'(irq), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        xfer(1'b0, A_CTRL, 0, 8, rd, ak, aa);
        check("ctrl_ack", 32'(ak), 32'd1);
        check("ctrl_rst", rd, 32'h1);
        check("ctrl_ackw", 32'(aa), 32'd0);
        xfer(1'b0, A_STAT, 0, 8, rd, ak, aa);
        check("stat_ack", 32'(ak), 32'd1);
        check("stat_rst", rd, 32'h0);
        check("stat_ackw", 32'(aa), 32'd0);
        rd_chk("wcnt_rst", A_WCNT, 32'd0);

        // single word, grant held high
        gnt = 1'b1;
        wr("w1", 32'h3000_8010, 32'hDEAD_BEEF);
        check("w1_req", 32'(g_req), 32'd1);
        check("w1_addr", g_addr, 32'd4);
        check("w1_data", g_data, 32'hDEAD_BEEF);
        check("w1_mask", 32'(g_mask), 32'hF);
        rd_chk("w1_wcnt", A_WCNT, 32'd1);
        rd_chk("w1_stat", A_STAT, 32'h200);

        // fill to full, stall, then drain
        wr("clr_done", A_STAT, 32'h300);
        wr("clr_wcnt", A_WCNT, 32'h0);
        gnt = 1'b0;
        q_addr.delete(); q_data.delete();
        for (int k = 0; k < 4; k++)
            wr("fill", 32'h3000_8100 + 32'(4*k), 32'hA000_0000 + 32'(k));
        xfer(1'b1, 32'h3000_8110, 32'hA000_0004, 6, rd, ak, aa);
        check("stall_noack", 32'(ak), 32'd0);
        rd_chk("full_stat", A_STAT, 32'h14);
        check("full_crst", 32'(crst), 32'd1);
        gnt = 1'b1;
        xfer(1'b1, 32'h3000_8110, 32'hA000_0004, 10, rd, ak, aa);
        check("retry_ack", 32'(ak), 32'd1);
        repeat (6) @(posedge clk);
        #1;
        check("drain_n", 32'(q_addr.size()), 32'd5);
        for (int k = 0; k < 5 && k < q_addr.size(); k++) begin
            check("drain_addr", q_addr[k], 32'h40 + 32'(k));
            check("drain_data", q_data[k], 32'hA000_0000 + 32'(k));
        end
        rd_chk("drain_stat", A_STAT, 32'h200);
        rd_chk("drain_wcnt", A_WCNT, 32'd5);

        // release hold with entries still queued
        wr("clr_done2", A_STAT, 32'h200);
        gnt = 1'b0;
        for (int k = 0; k < 3; k++)
            wr("q3", 32'h3000_8200 + 32'(4*k), 32'hB000_0000 + 32'(k));
        wr("ctrl2", A_CTRL, 32'h2);
        check("rel_crst", 32'(crst), 32'd1);
        check("rel_irq0", 32'(irq), 32'd0);
        gnt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rel_crst_i", 32'(crst), (i == 2) ? 32'd0 : 32'd1);
        end
        check("rel_irq1", 32'(irq), 32'd1);
        wr("w1c_done", A_STAT, 32'h200);
        check("irq_clr", 32'(irq), 32'd0);

        // error paths and decode miss
        wr("nohold", 32'h3000_8300, 32'h1234_5678);
        check("nohold_req", 32'(g_req), 32'd0);
        check("nohold_req2", 32'(req), 32'd0);
        rd_chk("nohold_stat", A_STAT, 32'h100);
        wr("w1c_err", A_STAT, 32'h100);
        rd_chk("err_clr", A_STAT, 32'h0);
        rd_chk("memrd", 32'h3000_8000, 32'h0);
        rd_chk("memrd_stat", A_STAT, 32'h100);
        xfer(1'b0, 32'h3100_0000, 0, 6, rd, ak, aa);
        check("miss_noack", 32'(ak), 32'd0);
        rd_chk("other_off", 32'h3000_0010, 32'h0);

        // async reset mid-drain
        wr("clr_err2", A_STAT, 32'h100);
        wr("hold_on", A_CTRL, 32'h1);
        gnt = 1'b0;
        wr("r1", 32'h3000_8400, 32'hC000_0000);
        wr("r2", 32'h3000_8404, 32'hC000_0001);
        check("pre_rst_req", 32'(req), 32'd1);
        gnt = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("arst_req", 32'(req), 32'd0);
        check("arst_crst", 32'(crst), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        rd_chk("post_stat", A_STAT, 32'h0);
        rd_chk("post_ctrl", A_CTRL, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
